// File: rtl/audio_pkg.sv
// Shared constants for the sound-effect sequencer: effect table, silence level,
// state encoding and the volume scaler.
package audio_pkg;

  localparam int unsigned NUM_SFX_MAX = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned TBL_ADDR_W  = 14;
  localparam int unsigned LEN_W       = 14;

  localparam int unsigned SFX_SHOT    = 0;
  localparam int unsigned SFX_HIT     = 1;
  localparam int unsigned SFX_ENGINE  = 2;
  localparam int unsigned SFX_EXPLODE = 3;

  localparam logic [7:0] SILENCE = 8'h80;

  // Start address and length (samples) of each effect in the shared ROM.
  localparam logic [TBL_ADDR_W-1:0] SFX_START [NUM_SFX_MAX] =
    '{14'h0010, 14'h0020, 14'h0030, 14'h0040};
  localparam logic [LEN_W-1:0] SFX_LEN [NUM_SFX_MAX] =
    '{14'd3, 14'd4, 14'd4, 14'd5};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ISSUE,
    ST_CAPTURE,
    ST_LAST
  } state_t;

  // Attenuate around the midpoint so silence stays at 8'h80 for every volume.
  function automatic logic [7:0] scale(input logic [7:0] data, input logic [1:0] vol);
    logic signed [8:0] s;
    logic signed [8:0] a;
    s = $signed({1'b0, data}) - 9'sd128;
    a = s >>> vol;
    return 8'(a + 9'sd128);
  endfunction

endpackage

// File: rtl/audio_sfx_sequencer_divider.sv
// Free-running sample-rate divider; tick is high for the cycle where count==CLK_DIV-1.
module sample_rate_divider #(
  parameter int unsigned CLK_DIV = 12500
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] count;

  // tick is registered one count early so it lines up with count==CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == CNT_W'(CLK_DIV - 2));
      count <= (count == CNT_W'(CLK_DIV - 1)) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_sfx_sequencer.sv
// Plays prioritised PCM sound effects from a shared sample ROM at a fixed sample
// rate, with volume attenuation, feeding audio_PWM.music_data.
module audio_sfx_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 12500,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned NUM_SFX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SFX-1:0] sfx_req,
  input  logic [1:0]        volume,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        music_data,
  output logic              busy,
  output logic [1:0]        active_sfx,
  output logic              sfx_done
);

  logic              tick;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;

  sample_rate_divider #(.CLK_DIV(CLK_DIV)) u_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Highest set request bit wins.
  always_comb begin
    req_idx = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (sfx_req[i]) req_idx = IDX_W'(i);
    end
  end

  assign accept = (|sfx_req) && (SFX_LEN[req_idx] != '0) &&
                  ((state == ST_IDLE) || (req_idx >= active_sfx));

  // Acceptance overrides any sample step in flight; music_data holds until the
  // new effect's first sample is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      music_data <= SILENCE;
      busy       <= 1'b0;
      active_sfx <= '0;
      sfx_done   <= 1'b0;
      ptr        <= '0;
      remaining  <= '0;
    end else begin
      sfx_done <= 1'b0;
      if (accept) begin
        ptr        <= ADDR_W'(SFX_START[req_idx]);
        remaining  <= SFX_LEN[req_idx];
        active_sfx <= req_idx;
        busy       <= 1'b1;
        state      <= ST_WAIT_TICK;
      end else begin
        case (state)
          ST_IDLE: music_data <= SILENCE;
          ST_WAIT_TICK: begin
            if (tick) begin
              rom_addr <= ptr;
              state    <= ST_ISSUE;
            end
          end
          ST_ISSUE: state <= ST_CAPTURE;
          ST_CAPTURE: begin
            music_data <= scale(rom_data, volume);
            ptr        <= ptr + ADDR_W'(1);
            remaining  <= remaining - LEN_W'(1);
            state      <= (remaining == LEN_W'(1)) ? ST_LAST : ST_WAIT_TICK;
          end
          ST_LAST: begin
            if (tick) begin
              music_data <= SILENCE;
              busy       <= 1'b0;
              active_sfx <= '0;
              sfx_done   <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sfx_sequencer.sv
// Directed bench for audio_sfx_sequencer with a synchronous ROM model (CLK_DIV=8).
module tb_audio_sfx_sequencer;

  localparam int unsigned CLK_DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sfx_req = '0;
  logic [1:0]  volume = '0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  music_data;
  logic        busy;
  logic [1:0]  active_sfx;
  logic        sfx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_addr_cyc = 0;

  logic [7:0] rom [256];

  audio_sfx_sequencer #(.CLK_DIV(CLK_DIV), .ADDR_W(14), .NUM_SFX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sfx_req    (sfx_req),
    .volume     (volume),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .music_data (music_data),
    .busy       (busy),
    .active_sfx (active_sfx),
    .sfx_done   (sfx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr[7:0]];
    if (!reset && sfx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] r);
    sfx_req = r;
    @(negedge clk);
    sfx_req = '0;
  endtask

  // Wait for the next address, then check the 1-cycle hold and the new sample.
  task automatic expect_sample(input logic [13:0] addr, input logic [7:0] prev,
                               input logic [7:0] data, input bit check_gap);
    logic [13:0] old;
    int n;
    old = rom_addr;
    n = 0;
    while (rom_addr === old && n < 4 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    check("rom_addr", 32'(rom_addr), 32'(addr));
    if (check_gap) check("tick_gap", 32'(cyc - last_addr_cyc), CLK_DIV);
    last_addr_cyc = cyc;
    @(negedge clk);
    check("music_hold", 32'(music_data), 32'(prev));
    @(negedge clk);
    check("music_data", 32'(music_data), 32'(data));
  endtask

  task automatic expect_done();
    int n;
    n = 0;
    while (sfx_done !== 1'b1 && n < 4 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    check("sfx_done", 32'(sfx_done), 32'd1);
    check("done_gap", 32'(cyc - last_addr_cyc), CLK_DIV);
    check("done_music", 32'(music_data), 32'h80);
    check("done_busy", 32'(busy), 32'd0);
    check("done_active", 32'(active_sfx), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(sfx_done), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[16] = 8'hFF;
    rom[17] = 8'h00;
    rom[18] = 8'h90;

    repeat (3) @(negedge clk);
    check("rst_music", 32'(music_data), 32'h80);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_active", 32'(active_sfx), 32'd0);
    check("rst_done", 32'(sfx_done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle", 32'({music_data, busy, rom_addr}), 32'({8'h80, 1'b0, 14'h0}));
    end

    // Effect 0 at full scale.
    pulse(4'b0001);
    check("e0_busy", 32'(busy), 32'd1);
    check("e0_active", 32'(active_sfx), 32'd0);
    expect_sample(14'h10, 8'h80, 8'hFF, 1'b0);
    expect_sample(14'h11, 8'hFF, 8'h00, 1'b1);
    expect_sample(14'h12, 8'h00, 8'h90, 1'b1);
    expect_done();

    // Effect 0 at volume 2.
    volume = 2'd2;
    pulse(4'b0001);
    expect_sample(14'h10, 8'h80, 8'h9F, 1'b0);
    expect_sample(14'h11, 8'h9F, 8'h60, 1'b1);
    expect_sample(14'h12, 8'h60, 8'h84, 1'b1);
    expect_done();
    volume = 2'd0;

    // Lower-priority request is ignored.
    pulse(4'b0010);
    check("e1_active", 32'(active_sfx), 32'd1);
    expect_sample(14'h20, 8'h80, 8'h20, 1'b0);
    pulse(4'b0001);
    check("low_ignored", 32'(active_sfx), 32'd1);
    expect_sample(14'h21, 8'h20, 8'h21, 1'b1);
    expect_sample(14'h22, 8'h21, 8'h22, 1'b1);
    expect_sample(14'h23, 8'h22, 8'h23, 1'b1);
    expect_done();

    // Higher-priority request preempts without a done pulse for effect 1.
    pulse(4'b0010);
    expect_sample(14'h20, 8'h80, 8'h20, 1'b0);
    d0 = done_cnt;
    pulse(4'b1000);
    check("pre_active", 32'(active_sfx), 32'd3);
    check("pre_busy", 32'(busy), 32'd1);
    expect_sample(14'h40, 8'h20, 8'h40, 1'b0);
    expect_sample(14'h41, 8'h40, 8'h41, 1'b1);
    expect_sample(14'h42, 8'h41, 8'h42, 1'b1);
    expect_sample(14'h43, 8'h42, 8'h43, 1'b1);
    expect_sample(14'h44, 8'h43, 8'h44, 1'b1);
    expect_done();
    check("pre_done_count", 32'(done_cnt), 32'(d0 + 1));

    // Simultaneous requests pick the highest; equal priority restarts.
    pulse(4'b0110);
    check("multi_active", 32'(active_sfx), 32'd2);
    expect_sample(14'h30, 8'h80, 8'h30, 1'b0);
    expect_sample(14'h31, 8'h30, 8'h31, 1'b1);
    pulse(4'b0100);
    check("restart_active", 32'(active_sfx), 32'd2);
    expect_sample(14'h30, 8'h31, 8'h30, 1'b0);
    expect_sample(14'h31, 8'h30, 8'h31, 1'b1);
    expect_sample(14'h32, 8'h31, 8'h32, 1'b1);
    expect_sample(14'h33, 8'h32, 8'h33, 1'b1);
    expect_done();

    // Reset while in CAPTURE.
    d0 = done_cnt;
    pulse(4'b0001);
    n = 0;
    while (rom_addr !== 14'h10 && n < 4 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    check("cap_addr", 32'(rom_addr), 32'h10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_music", 32'(music_data), 32'h80);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_active", 32'(active_sfx), 32'd0);
    check("mid_rst_done", 32'(sfx_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt), 32'(d0));
    pulse(4'b0001);
    expect_sample(14'h10, 8'h80, 8'hFF, 1'b0);
    expect_sample(14'h11, 8'hFF, 8'h00, 1'b1);
    expect_sample(14'h12, 8'h00, 8'h90, 1'b1);
    expect_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
